// File: rtl/button_conditioner_pkg.sv
// Shared constants for the push-button conditioning path: channel indices
// feeding the SLC-3 core and the standard debounce interval.
package button_conditioner_pkg;

  localparam int BTN_RUN      = 0;
  localparam int BTN_CONTINUE = 1;

  // 10 ms at 100 MHz.
  localparam int DEBOUNCE_100MHZ_10MS = 1_000_000;

  // The counter must hold DEBOUNCE_CYCLES-1 without wrapping, with one value of margin.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, stability counter, accepted level
// register, and registered one-cycle rise/fall pulses.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_100MHZ_10MS
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             lvl;
  logic [CNT_W-1:0] cnt;
  logic             rise_q;
  logic             fall_q;

  // NOTE: every register here is updated with <= so that s1->s2->cnt->lvl
  // behave as a true pipeline; blocking assignments would collapse the stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      lvl    <= 1'b0;
      cnt    <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1     <= btn;
      s2     <= s1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        lvl    <= s2;
        cnt    <= '0;
        rise_q <= s2;
        fall_q <= ~s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign level = lvl;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/button_conditioner.sv
// Board push-button front end: optional polarity inversion, then one
// independent debounce channel per button.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_100MHZ_10MS,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_i,
  output logic [NUM_BTN-1:0] btn_level_o,
  output logic [NUM_BTN-1:0] btn_rise_o,
  output logic [NUM_BTN-1:0] btn_fall_o
);

  // Internally a pressed button always reads as 1.
  logic [NUM_BTN-1:0] btn_pressed;
  assign btn_pressed = ACTIVE_LOW ? ~btn_i : btn_i;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .btn  (btn_pressed[g]),
      .level(btn_level_o[g]),
      .rise (btn_rise_o[g]),
      .fall (btn_fall_o[g])
    );
  end

endmodule
